// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, fetches one instruction per req/ack, hands it to decode.
// Latency: instr_valid rises one cycle after imem_ack; next fetch starts one cycle after consume.
// Backpressure: holds instr until instr_ready (no prefetch); memory may stall indefinitely. Optional FETCH_PERF_CNT_EN adds counters.
module fetch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] link_addr,
  input  logic              jump,
  input  logic              branch,
  input  logic              bnq,
  input  logic              zero,
`ifdef FETCH_PERF_CNT_EN
  input  logic [31:0]       branch_imm,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       redirect_cnt
`else
  input  logic [31:0]       branch_imm
`endif
);

  typedef enum logic [1:0] {RST_WAIT, FETCH, HOLD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] next_pc;
  logic [31:0]       imm_sh;
  logic              br_taken;
  logic              consume;

  assign pc4       = instr_pc + ADDR_W'(4);
  assign imm_sh    = branch_imm << 2;
  assign br_tgt    = pc4 + ADDR_W'(imm_sh);
  assign jump_tgt  = {pc4[ADDR_W-1:28], instr[25:0], 2'b00};
  // An illegal beq+bne combination redirects if either condition holds.
  assign br_taken  = (branch && zero) || (bnq && !zero);
  assign consume   = (state == HOLD) && instr_ready;
  assign imem_addr = pc;
  assign link_addr = pc4;

  always_comb begin
    next_pc = pc4;
    if (jump)
      next_pc = jump_tgt;
    else if (br_taken)
      next_pc = br_tgt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RST_WAIT;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      case (state)
        RST_WAIT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        default: begin
          state       <= RST_WAIT;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt  <= '0;
      redirect_cnt <= '0;
    end else if (consume) begin
      retired_cnt <= retired_cnt + 32'd1;
      if (next_pc != pc4)
        redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer against a next-PC reference model.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] link_addr;
  logic        jump = 1'b0, branch = 1'b0, bnq = 1'b0, zero = 1'b0;
  logic [31:0] branch_imm = '0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt, redirect_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] last_w = 32'h0;
  int exp_ret = 0;
  int exp_redir = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .link_addr(link_addr), .jump(jump), .branch(branch), .bnq(bnq), .zero(zero),
`ifdef FETCH_PERF_CNT_EN
    .branch_imm(branch_imm), .retired_cnt(retired_cnt), .redirect_cnt(redirect_cnt)
`else
    .branch_imm(branch_imm)
`endif
  );

  always #5 clk = ~clk;

  // Reference next-PC rule written directly from the architectural definition.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w,
                                           input logic j, input logic b, input logic n,
                                           input logic z, input logic [31:0] imm);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    if (j) return (pc4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
    if ((b && z) || (n && !z)) return pc4 + imm * 4;
    return pc4;
  endfunction

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!imem_req) begin
      checks++; errors++;
      $display("FAIL wait_req timeout: imem_req=%0b required=1", imem_req);
    end
  endtask

  task automatic serve(input logic [31:0] w, input int dly);
    wait_req();
    repeat (dly) begin @(posedge clk); #1; end
    imem_ack = 1'b1; imem_rdata = w; last_w = w;
    @(posedge clk); #1;
    imem_ack = 1'b0; imem_rdata = $urandom;
  endtask

  task automatic consume(input logic j, input logic b, input logic n, input logic z,
                         input logic [31:0] imm);
    logic [31:0] nxt;
    nxt = ref_next(exp_pc, last_w, j, b, n, z, imm);
    exp_ret++;
    if (nxt != exp_pc + 32'd4) exp_redir++;
    jump = j; branch = b; bnq = n; zero = z; branch_imm = imm; instr_ready = 1'b1;
    @(posedge clk); #1;
    jump = 0; branch = 0; bnq = 0; zero = 0; branch_imm = $urandom; instr_ready = 1'b0;
    exp_pc = nxt;
  endtask

  task automatic goto_pc(input logic [31:0] target);
    serve(32'h0, 0);
    consume(1'b0, 1'b1, 1'b0, 1'b1, (target - exp_pc - 32'd4) >> 2);
  endtask

  task automatic test_reset();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 ||
        instr_pc !== 32'h0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: req=%0b valid=%0b instr=%h pc=%h addr=%h required 0 0 0 0 0",
               imem_req, instr_valid, instr, instr_pc, imem_addr);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_wait_ack_ignored: req=%0b valid=%0b addr=%h required 1 0 0",
               imem_req, instr_valid, imem_addr);
    end
    imem_rdata = 32'h2001_0005; last_w = 32'h2001_0005;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h2001_0005 || instr_pc !== 32'h0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL first_fetch: valid=%0b instr=%h pc=%h req=%0b required 1 20010005 0 0",
               instr_valid, instr, instr_pc, imem_req);
    end
    exp_pc = 32'h0;
    consume(0, 0, 0, 0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL second_addr: req=%0b addr=%h required 1 00000004", imem_req, imem_addr);
    end
  endtask

  task automatic test_hold_stall();
    logic [31:0] w;
    w = $urandom;
    serve(w, 2);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== w || instr_pc !== exp_pc || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: valid=%0b instr=%h pc=%h req=%0b required 1 %h %h 0",
                 i, instr_valid, instr, instr_pc, imem_req, w, exp_pc);
      end
      @(posedge clk); #1;
    end
    consume(0, 0, 0, 0, 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== exp_pc) begin
      errors++;
      $display("FAIL hold_single_advance: req=%0b valid=%0b addr=%h required 1 0 %h",
               imem_req, instr_valid, imem_addr, exp_pc);
    end
  endtask

  task automatic test_branch();
    logic [3:0] bv [3] = '{4'b1010, 4'b1000, 4'b0100};
    logic [31:0] imms [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h3};
    logic [31:0] tgts [3] = '{32'h0C, 32'h14, 32'h20};
    for (int i = 0; i < 3; i++) begin
      goto_pc(32'h10);
      serve($urandom, 0);
      consume(1'b0, bv[i][3], bv[i][2], bv[i][1], imms[i]);
      checks++;
      if (imem_addr !== tgts[i] || imem_addr !== exp_pc) begin
        errors++;
        $display("FAIL branch_case[%0d]: addr=%h required %h", i, imem_addr, tgts[i]);
      end
    end
  endtask

  task automatic test_jump();
    for (int i = 0; i < 2; i++) begin
      goto_pc(32'h1000_0040);
      serve(32'hFC00_0100, 1);
      checks++;
      if (link_addr !== 32'h1000_0044) begin
        errors++;
        $display("FAIL jump_link[%0d]: link=%h required 10000044", i, link_addr);
      end
      consume(1'b1, i[0], 1'b0, i[0], 32'h7);
      checks++;
      if (imem_addr !== 32'h1000_0400) begin
        errors++;
        $display("FAIL jump_target[%0d]: addr=%h required 10000400", i, imem_addr);
      end
    end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    serve($urandom & 32'h03FF_FFFF, 0);
    consume(0, 0, 0, 0, 32'h0);
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap: addr=%h required 00000000", imem_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] w, imm;
    logic j, b, n, z;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) == 0) goto_pc($urandom & 32'hFFFF_FFFC);
      w = $urandom;
      serve(w, $urandom_range(0, 3));
      checks++;
      if (instr_valid !== 1'b1 || instr !== w || instr_pc !== exp_pc ||
          link_addr !== exp_pc + 32'd4 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL rand_capture[%0d]: valid=%0b instr=%h pc=%h link=%h req=%0b required 1 %h %h %h 0",
                 k, instr_valid, instr, instr_pc, link_addr, imem_req, w, exp_pc, exp_pc + 32'd4);
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      j = ($urandom_range(0, 3) == 0);
      b = $urandom_range(0, 1);
      n = ($urandom_range(0, 2) == 0);
      z = $urandom_range(0, 1);
      imm = $urandom_range(0, 1) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
      consume(j, b, n, z, imm);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        errors++;
        $display("FAIL rand_next[%0d]: req=%0b addr=%h required 1 %h", k, imem_req, imem_addr, exp_pc);
      end
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    logic [31:0] r0, d0;
    checks++;
    if (retired_cnt !== 32'(exp_ret) || redirect_cnt !== 32'(exp_redir)) begin
      errors++;
      $display("FAIL perf_running: ret=%0d redir=%0d required %0d %0d",
               retired_cnt, redirect_cnt, exp_ret, exp_redir);
    end
    r0 = retired_cnt; d0 = redirect_cnt;
    serve(32'h0, 0);         consume(0, 0, 0, 0, 32'h0);
    serve(32'h0, 1);         consume(0, 1, 0, 1, 32'h5);
    serve(32'h0000_0040, 0); consume(1, 0, 0, 0, 32'h0);
    serve(32'h0, 2);         consume(0, 1, 0, 0, 32'h5);
    checks++;
    if (retired_cnt - r0 !== 32'd4 || redirect_cnt - d0 !== 32'd2) begin
      errors++;
      $display("FAIL perf_four: ret_delta=%0d redir_delta=%0d required 4 2",
               retired_cnt - r0, redirect_cnt - d0);
    end
  endtask
`endif

  task automatic test_reset_mid_fetch();
    wait_req();
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL midfetch_reset: req=%0b valid=%0b addr=%h required 0 0 0",
               imem_req, instr_valid, imem_addr);
    end
    @(posedge clk); #1;
    imem_ack = 1'b0; rst_n = 1'b1;
    exp_pc = 32'h0; exp_ret = 0; exp_redir = 0;
    @(posedge clk); #1;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL midfetch_restart: valid=%0b req=%0b addr=%h required 0 1 0",
               instr_valid, imem_req, imem_addr);
    end
    serve(32'hABCD_0001, 0);
    checks++;
    if (instr !== 32'hABCD_0001 || instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL midfetch_refetch: instr=%h pc=%h required abcd0001 0", instr, instr_pc);
    end
  endtask

  initial begin
    test_reset();
    test_hold_stall();
    test_branch();
    test_jump();
    test_wrap();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
